rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that shares a single downstream resource (bus or datapath slot) between four clients.
- Registers a one-hot grant vector and its 2-bit binary encoding, so the consumer can mux on either form.
- Bounds each holder's tenure with a hold timeout so no requester can starve the others.
- Sits between client request lines and the shared-resource select mux.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester keeps the grant while others are pending; legal range 2..256.
- CNT_W, $clog2(MAX_HOLD), width of the hold counter; derived from MAX_HOLD, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  4  level request per client; bit i = client i.
- gnt  output  4  one-hot registered grant; all zeros when nothing is granted.
- gnt_idx  output  2  binary index of the granted client; 0 when gnt_valid=0.
- gnt_valid  output  1  high when exactly one gnt bit is set.

Behaviour:
- One clock and one reset domain. Reset is synchronous and active-high: it is sampled only on the rising edge of clk.
- Reset values: gnt=4'b0000, gnt_idx=2'd0, gnt_valid=0, hold counter=0, priority pointer last=2'd3.
- Because last resets to 3, client 0 has highest priority on the first arbitration.
- All outputs are registered. A request sampled at edge N produces a grant visible after edge N (latency 1 cycle).
- State IDLE (gnt_valid=0):
  - At each edge, if req != 0, grant the first set bit searching from (last+1) mod 4 upward with wrap.
  - Go to GRANT, load last=winner, counter=0.
  - If req == 0, stay in IDLE.
- State GRANT, holder h:
  - Release: if req[h]=0 at the edge, re-arbitrate on the current req in the same edge (zero-bubble hand-off). Search starts at (h+1) mod 4.
    - If req == 0, go to IDLE and clear all outputs.
    - Otherwise grant the winner and reset the counter to 0.
  - Timeout: if req[h]=1, counter == MAX_HOLD-1, and any other req bit is set, grant the next requester after h in round-robin order. The counter resets to 0 and last updates.
  - Hold: if req[h]=1 and (counter < MAX_HOLD-1 or no other request is pending), keep the grant.
    - Counter increments and saturates at MAX_HOLD-1.
    - A saturated holder is pre-empted on the first edge another request appears.
- gnt_idx encoding: 0001→0, 0010→1, 0100→2, 1000→3. gnt, gnt_idx and gnt_valid always update together.
- Invariant: gnt is always one-hot or zero, never multi-hot. Verification asserts this every cycle.
- Grant changes only at clock edges; the request-to-grant path has no combinational output.
- A newly asserted request from a non-holder never pre-empts the holder before timeout.
- Reset mid-grant: the next edge with rst=1 forces the reset values regardless of req. The first arbitration after reset starts from client 0.
- Fairness bound: a continuously requesting client is granted within 3*MAX_HOLD+1 cycles.

Test Plan:
- Reset then req=4'b1111 held: gnt=0001/idx 0 one cycle later, then after 8 cycles 0010/idx 1, then 0100, then 1000, then wraps back to 0001. Each grant lasts exactly 8 cycles.
- Single requester req=4'b0100 held 20 cycles: gnt=0100, idx 2 continuously; no drop at timeout. Then req=0 gives gnt=0000, gnt_valid=0 one cycle later.
- Zero-bubble hand-off: holder 0 with req=4'b0011, then drop req[0] in cycle 3: gnt goes 0001→0010 at the next edge, with no cycle of gnt_valid=0.
- Late arrival at saturation: req=4'b0001 for 12 cycles (counter saturated), then req=4'b1001: gnt moves to 1000/idx 3 at the next edge.
- Reset mid-operation: grant on client 2, assert rst for 1 cycle with req=4'b1111: outputs go to 0 after the edge. After release, the first grant is 0001.
- Round-robin skip: last=1, req=4'b1001 from IDLE: gnt=1000 (search order 2,3,0,1). After release, with req=4'b1001 again, gnt=0001.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-client round-robin arbiter with bounded hold tenure
// Grant, index and valid are registered together so the consumer may mux on either form.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_e;

  state_e           state_q;
  logic [1:0]       last_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       gnt_q;
  logic [1:0]       idx_q;
  logic             valid_q;

  logic [1:0]       search_start;
  logic [1:0]       cand;
  logic [1:0]       win_idx;
  logic             win_found;
  logic             holder_req;
  logic             others_pending;
  logic             timeout;

  // last_q always equals the holder while granting, so one search start serves both states;
  // the holder is reached last in the search, so other requesters always win first.
  always_comb begin
    search_start   = last_q + 2'd1;
    cand           = 2'd0;
    win_idx        = 2'd0;
    win_found      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = search_start + 2'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    holder_req     = |(req & gnt_q);
    others_pending = |(req & ~gnt_q);
    timeout        = (cnt_q == CNT_MAX) && others_pending;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_q <= S_GRANT;
            last_q  <= win_idx;
            cnt_q   <= '0;
            gnt_q   <= 4'b0001 << win_idx;
            idx_q   <= win_idx;
            valid_q <= 1'b1;
          end
        end
        S_GRANT: begin
          if (!holder_req || timeout) begin
            if (win_found) begin
              last_q  <= win_idx;
              cnt_q   <= '0;
              gnt_q   <= 4'b0001 << win_idx;
              idx_q   <= win_idx;
              valid_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              gnt_q   <= 4'b0000;
              idx_q   <= 2'd0;
              valid_q <= 1'b0;
            end
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - directed-vector bench for rr_arbiter_4
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  int checks = 0;
  int errors = 0;

  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] ei, input logic ev);
    checks++;
    assert (gnt === eg && gnt_idx === ei && gnt_valid === ev && $onehot0(gnt))
    else begin
      errors++;
      $error("FAIL %s: got gnt=%b idx=%0d valid=%b, expected gnt=%b idx=%0d valid=%b",
             tag, gnt, gnt_idx, gnt_valid, eg, ei, ev);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] eg;
    rst = 1'b1;
    req = 4'b0000;
    tick();
    tick();
    chk("reset", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;

    // all four requesting: 8-cycle tenures rotating 0,1,2,3,0
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      for (int c = 0; c < 8; c++) begin
        tick();
        chk($sformatf("rotate_k%0d_c%0d", k, c), eg, 2'(k % 4), 1'b1);
      end
    end

    // lone requester keeps grant past the hold limit
    do_reset();
    chk("reset2", 4'b0000, 2'd0, 1'b0);
    req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("single_c%0d", c), 4'b0100, 2'd2, 1'b1);
    end
    req = 4'b0000;
    tick();
    chk("single_release", 4'b0000, 2'd0, 1'b0);

    // zero-bubble hand-off; pending client 1 must not pre-empt early
    do_reset();
    req = 4'b0011;
    tick();
    chk("handoff_c1", 4'b0001, 2'd0, 1'b1);
    tick();
    chk("handoff_c2", 4'b0001, 2'd0, 1'b1);
    tick();
    chk("handoff_c3", 4'b0001, 2'd0, 1'b1);
    req = 4'b0010;
    tick();
    chk("handoff_move", 4'b0010, 2'd1, 1'b1);

    // late arrival against a saturated holder
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk($sformatf("sat_c%0d", c), 4'b0001, 2'd0, 1'b1);
    end
    req = 4'b1001;
    tick();
    chk("sat_preempt", 4'b1000, 2'd3, 1'b1);

    // reset while client 2 holds
    do_reset();
    req = 4'b0100;
    tick();
    chk("midrst_grant", 4'b0100, 2'd2, 1'b1);
    rst = 1'b1;
    req = 4'b1111;
    tick();
    chk("midrst_cleared", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    tick();
    chk("midrst_first", 4'b0001, 2'd0, 1'b1);

    // priority pointer skip from idle
    do_reset();
    req = 4'b0010;
    tick();
    chk("skip_g1", 4'b0010, 2'd1, 1'b1);
    req = 4'b0000;
    tick();
    chk("skip_idle1", 4'b0000, 2'd0, 1'b0);
    req = 4'b1001;
    tick();
    chk("skip_g3", 4'b1000, 2'd3, 1'b1);
    req = 4'b0000;
    tick();
    chk("skip_idle2", 4'b0000, 2'd0, 1'b0);
    req = 4'b1001;
    tick();
    chk("skip_g0", 4'b0001, 2'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
